// File: rtl/keystone_frame_gate.sv
// AXI4-Stream front end for the keystone core: aligns to SOF, buffers through a
// 2-entry skid FIFO, and latches the coefficient bank/enable only at frame start.
module keystone_frame_gate #(
    parameter int DATA_W     = 64,
    parameter int COEFF_W    = 32,
    parameter int NUM_COEFFS = 8,
    parameter int LINE_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clock_en,

    input  logic [DATA_W-1:0]             s_tdata,
    input  logic                          s_tvalid,
    input  logic                          s_tuser,
    input  logic                          s_tlast,
    output logic                          s_tready,

    output logic [DATA_W-1:0]             m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tuser,
    output logic                          m_tlast,
    input  logic                          m_tready,

    input  logic                          enable_in,
    input  logic [NUM_COEFFS*COEFF_W-1:0] coeff_in,
    input  logic [LINE_W-1:0]             line_length,
    output logic                          enable_out,
    output logic [NUM_COEFFS*COEFF_W-1:0] coeff_out,
    output logic [15:0]                   frame_count,
    output logic                          line_err,
    input  logic                          line_err_clr
);

    localparam int ENTRY_W = DATA_W + 2;

    typedef enum logic {
        SEEK_SOF = 1'b0,
        PASS     = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      occ_q, occ_d;
    logic                            rd_ptr_q, wr_ptr_q;
    logic [ENTRY_W-1:0]              mem_q [2];
    logic [LINE_W-1:0]               beat_q, beat_d, beat_len;
    logic                            line_err_q, line_err_d, err_set;
    logic [15:0]                     frame_q;
    logic [NUM_COEFFS*COEFF_W-1:0]   coeff_q;
    logic                            enable_q;

    logic accept, sof_acc, push, pop;
    logic [ENTRY_W-1:0] head;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d  = state_q;
        s_tready = 1'b0;
        if (clock_en && !reset) begin
            case (state_q)
                SEEK_SOF: s_tready = 1'b1;
                PASS:     s_tready = (occ_q < 2'd2);
                default:  s_tready = 1'b0;
            endcase
        end
        if (sof_acc) state_d = PASS;
    end

    assign accept  = s_tvalid & s_tready;
    assign sof_acc = accept & s_tuser;
    // Outside PASS only the SOF beat enters the buffer; everything before it is dropped.
    assign push    = accept & ((state_q == PASS) | s_tuser);
    assign pop     = m_tvalid & m_tready;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Beat count including the current beat; an SOF always restarts the line at 1.
    assign beat_len = s_tuser ? LINE_W'(1) : beat_q + LINE_W'(1);

    always_comb begin
        beat_d  = beat_q;
        err_set = 1'b0;
        if (push) begin
            if (s_tlast) begin
                beat_d = '0;
                if (line_length != '0 && beat_len != line_length) err_set = 1'b1;
            end else begin
                beat_d = beat_len;
            end
        end
        if (sof_acc && state_q == PASS && beat_q != '0) err_set = 1'b1;
        line_err_d = err_set | (line_err_q & ~line_err_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SEEK_SOF;
            occ_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            beat_q     <= '0;
            line_err_q <= 1'b0;
            frame_q    <= '0;
            coeff_q    <= '0;
            enable_q   <= 1'b0;
        end else if (clock_en) begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            beat_q     <= beat_d;
            line_err_q <= line_err_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            if (sof_acc) begin
                coeff_q  <= coeff_in;
                enable_q <= enable_in;
                frame_q  <= frame_q + 16'd1;
            end
        end
    end

    // NOTE: storage is left unreset; outputs are masked while empty so stale entries never show.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {s_tdata, s_tuser, s_tlast};
    end

    assign head     = mem_q[rd_ptr_q];
    assign m_tvalid = (occ_q != 2'd0) & clock_en;
    assign m_tdata  = (occ_q != 2'd0) ? head[ENTRY_W-1:2] : '0;
    assign m_tuser  = (occ_q != 2'd0) & head[1];
    assign m_tlast  = (occ_q != 2'd0) & head[0];

    assign enable_out  = enable_q;
    assign coeff_out   = coeff_q;
    assign frame_count = frame_q;
    assign line_err    = line_err_q;

endmodule

// File: tb/tb_keystone_frame_gate.sv
// Directed bench for keystone_frame_gate: scoreboard of forwarded beats plus
// checks of latching, frame counting, line errors, reset flush and clock enable.
module tb_keystone_frame_gate;

    localparam int DATA_W = 64, COEFF_W = 32, NUM_COEFFS = 8, LINE_W = 16;
    localparam int CW = NUM_COEFFS * COEFF_W;

    logic              clock, reset, clock_en;
    logic [DATA_W-1:0] s_tdata, m_tdata;
    logic              s_tvalid, s_tuser, s_tlast, s_tready;
    logic              m_tvalid, m_tuser, m_tlast, m_tready;
    logic              enable_in, enable_out, line_err, line_err_clr;
    logic [CW-1:0]     coeff_in, coeff_out;
    logic [LINE_W-1:0] line_length;
    logic [15:0]       frame_count;

    int checks = 0;
    int failures = 0;
    int seq = 0;
    int cyc = 0;
    int n_out = 0;
    logic [DATA_W+1:0] sb [$];
    int hs_q [$];

    keystone_frame_gate #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .NUM_COEFFS(NUM_COEFFS), .LINE_W(LINE_W)) dut (
        .clock(clock), .reset(reset), .clock_en(clock_en),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready),
        .enable_in(enable_in), .coeff_in(coeff_in), .line_length(line_length),
        .enable_out(enable_out), .coeff_out(coeff_out), .frame_count(frame_count),
        .line_err(line_err), .line_err_clr(line_err_clr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every downstream handshake is compared against the scoreboard head.
    always @(negedge clock) begin
        if (!reset && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", m_tdata, '0);
            end else begin
                logic [DATA_W+1:0] e;
                e = sb.pop_front();
                chk("m_tdata", m_tdata, e[DATA_W+1:2]);
                chk("m_tuser", m_tuser, e[1]);
                chk("m_tlast", m_tlast, e[0]);
            end
            hs_q.push_back(cyc);
            n_out++;
        end
    end

    // Drive one beat and hold it until accepted; forwarded beats go onto the scoreboard.
    task automatic send(input logic user, input logic last, input bit fwd);
        bit done;
        done     = 1'b0;
        s_tdata  = 64'hBEEF_0000_0000_0000 + 64'(seq);
        s_tuser  = user;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (s_tready === 1'b1) begin
                if (fwd) sb.push_back({s_tdata, user, last});
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        s_tvalid = 1'b0;
        chk("send_accept", CW'(done), CW'(1));
        seq++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clr_err();
        line_err_clr = 1'b1;
        tick(1);
        line_err_clr = 1'b0;
    endtask

    task automatic chk_no_gap(input string tag);
        for (int i = 1; i < hs_q.size(); i++) chk(tag, CW'(hs_q[i] - hs_q[i-1]), CW'(1));
    endtask

    initial begin
        reset = 1'b1; clock_en = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1; enable_in = 1'b0; coeff_in = {32{8'h11}}; line_length = 16'd4; line_err_clr = 1'b0;

        // Reset state
        tick(2);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_coeff_out", coeff_out, 0);
        chk("rst_enable_out", enable_out, 0);
        chk("rst_line_err", line_err, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_s_tready", s_tready, 1);

        // Pre-SOF beats are dropped, then a clean 4-beat line
        send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        chk("drop_m_tvalid", m_tvalid, 0);
        chk("drop_frame_count", frame_count, 0);
        hs_q.delete();
        send(1, 0, 1);
        chk("latency_m_tvalid", m_tvalid, 1);
        chk("latency_m_tuser", m_tuser, 1);
        send(0, 0, 1); send(0, 0, 1); send(0, 1, 1);
        tick(3);
        chk_no_gap("line1_no_gap");
        chk("line1_frame_count", frame_count, 1);
        chk("line1_line_err", line_err, 0);
        chk("line1_coeff_out", coeff_out, {32{8'h11}});

        // Backpressure: two beats fill the buffer, ready drops, then drains without gaps
        hs_q.delete();
        m_tready = 1'b0;
        send(1, 0, 1);
        send(0, 0, 1);
        coeff_in  = {32{8'h22}};
        enable_in = 1'b1;
        s_tdata = 64'hBEEF_0000_0000_0000 + 64'(seq); s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("full_s_tready", s_tready, 0);
            @(posedge clock);
            #1;
        end
        m_tready = 1'b1;
        send(0, 0, 1);
        send(0, 1, 1);
        tick(3);
        chk("bp_beats_out", CW'(hs_q.size()), CW'(4));
        chk_no_gap("bp_no_gap");
        chk("midframe_coeff_hold", coeff_out, {32{8'h11}});
        chk("midframe_enable_hold", enable_out, 0);

        // New SOF latches the new bank; short line raises a sticky error
        send(1, 0, 1);
        chk("sof_coeff_latch", coeff_out, {32{8'h22}});
        chk("sof_enable_latch", enable_out, 1);
        send(0, 0, 1);
        chk("short_pre_err", line_err, 0);
        send(0, 1, 1);
        chk("short_line_err", line_err, 1);
        tick(2);
        chk("short_err_sticky", line_err, 1);
        clr_err();
        chk("err_cleared", line_err, 0);

        // Clear and new error in the same cycle: set wins
        send(1, 0, 1);
        send(0, 0, 1);
        line_err_clr = 1'b1;
        send(0, 1, 1);
        line_err_clr = 1'b0;
        chk("set_wins_over_clr", line_err, 1);
        clr_err();
        chk("frame4_count", frame_count, 4);

        // Mid-line SOF at beat 2
        coeff_in = {32{8'h33}};
        send(1, 0, 1);
        send(0, 0, 1);
        chk("midsof_pre_err", line_err, 0);
        coeff_in = {32{8'h44}};
        send(1, 0, 1);
        chk("midsof_line_err", line_err, 1);
        chk("midsof_frame_count", frame_count, 6);
        chk("midsof_coeff_relatch", coeff_out, {32{8'h44}});
        send(0, 0, 1); send(0, 0, 1); send(0, 1, 1);
        clr_err();
        chk("midsof_err_cleared", line_err, 0);

        // line_length = 0 disables the length check
        line_length = 16'd0;
        send(1, 0, 1);
        send(0, 1, 1);
        chk("len0_no_err", line_err, 0);
        line_length = 16'd4;
        tick(3);

        // Reset with two beats buffered flushes and re-seeks SOF
        m_tready = 1'b0;
        send(1, 0, 1);
        send(0, 0, 1);
        chk("prefush_m_tvalid", m_tvalid, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sb.delete();
        chk("flush_m_tvalid", m_tvalid, 0);
        chk("flush_frame_count", frame_count, 0);
        m_tready = 1'b1;
        send(0, 0, 0); send(0, 0, 0);
        chk("reseek_drop", m_tvalid, 0);

        // clock_en low for 3 cycles mid-line
        send(1, 0, 1);
        send(0, 0, 1);
        clock_en = 1'b0;
        s_tdata = 64'hBEEF_0000_0000_0000 + 64'(seq); s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("ce_s_tready", s_tready, 0);
            chk("ce_m_tvalid", m_tvalid, 0);
            @(posedge clock);
            #1;
        end
        clock_en = 1'b1;
        send(0, 0, 1);
        send(0, 1, 1);
        tick(4);
        chk("ce_line_err", line_err, 0);
        chk("ce_frame_count", frame_count, 1);

        chk("sb_empty", CW'(sb.size()), CW'(0));
        chk("total_beats_out", CW'(n_out), CW'(26));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
